// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: ALU pass-through and req/ack data-bus loads/stores
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  input  logic [3:0]  memOp_i,
  input  logic [31:0] storeData_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [4:0]  writeAddr_o,
  output logic        writeEnable_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // Counter only needs to reach ACK_TIMEOUT-1; with no timeout it just wraps harmlessly.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [1:0]    ofs_q;

  logic          is_load, is_store, is_mem, aligned, timeout;
  logic [3:0]    be_nx;
  logic [31:0]   wdata_nx;
  logic [31:0]   load_data;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  // Decode the incoming op: class, alignment, byte enables and replicated store data
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    be_nx    = 4'b1111;
    wdata_nx = storeData_i;
    case (memOp_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        be_nx   = 4'b0001 << result_i[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        aligned = ~result_i[0];
        be_nx   = result_i[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        is_load = 1'b1;
        aligned = (result_i[1:0] == 2'b00);
      end
      OP_SB: begin
        is_store = 1'b1;
        be_nx    = 4'b0001 << result_i[1:0];
        wdata_nx = {4{storeData_i[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~result_i[0];
        be_nx    = result_i[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{storeData_i[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        aligned  = (result_i[1:0] == 2'b00);
      end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  // Timeout fires on the last allowed BUSY cycle; ack in that same cycle still wins
  always_comb begin
    timeout = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));
  end

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    case (ofs_q)
      2'd0:    rd_byte = bus_rdata_i[7:0];
      2'd1:    rd_byte = bus_rdata_i[15:8];
      2'd2:    rd_byte = bus_rdata_i[23:16];
      default: rd_byte = bus_rdata_i[31:24];
    endcase
    rd_half = ofs_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      default: load_data = bus_rdata_i;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and stall: hold upstream while a request is issued or pending
  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && aligned) begin
          state_nx = BUSY;
          stall_o  = 1'b1;
        end
      end
      BUSY: begin
        if (bus_ack_i || timeout) state_nx = IDLE;
        else                      stall_o  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: MEM/WB outputs, bus request registers, timeout counter, error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o      <= '0;
      writeAddr_o   <= '0;
      writeEnable_o <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_be_o      <= '0;
      bus_wdata_o   <= '0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      cnt           <= '0;
      op_q          <= '0;
      ofs_q         <= '0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          result_o    <= result_i;
          writeAddr_o <= writeAddr_i;
          if (is_mem && aligned) begin
            bus_req_o     <= 1'b1;
            bus_we_o      <= is_store;
            bus_addr_o    <= {result_i[31:2], 2'b00};
            bus_be_o      <= be_nx;
            bus_wdata_o   <= wdata_nx;
            op_q          <= memOp_i;
            ofs_q         <= result_i[1:0];
            cnt           <= '0;
            writeEnable_o <= 1'b0;
          end else if (is_mem) begin
            writeEnable_o <= 1'b0;
            misalign_o    <= 1'b1;
          end else begin
            writeEnable_o <= writeEnable_i;
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              result_o      <= load_data;
              writeAddr_o   <= writeAddr_i;
              writeEnable_o <= writeEnable_i;
            end else begin
              writeEnable_o <= 1'b0;
            end
          end else if (timeout) begin
            bus_req_o     <= 1'b0;
            bus_err_o     <= 1'b1;
            writeEnable_o <= 1'b0;
          end else begin
            cnt           <= cnt + 1'b1;
            writeEnable_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i;
  logic [3:0]  memOp_i;
  logic [31:0] storeData_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic [4:0]  writeAddr_o;
  logic        writeEnable_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic        misalign_o, bus_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    logic        we;
    logic        chk_res;
  } wb_t;
  wb_t sb[$];

  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .result_i(result_i), .writeAddr_i(writeAddr_i), .writeEnable_i(writeEnable_i),
    .memOp_i(memOp_i), .storeData_i(storeData_i),
    .stall_o(stall_o), .result_o(result_o), .writeAddr_o(writeAddr_o),
    .writeEnable_o(writeEnable_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one memory op and acks it on the delay-th BUSY cycle (delay 0 = never ack).
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic we, input int delay,
                         input logic [31:0] rdata, output int stalls,
                         output logic s_req, output logic s_we, output logic [31:0] s_addr,
                         output logic [3:0] s_be, output logic [31:0] s_wdata);
    memOp_i = op; result_i = addr; storeData_i = sdata;
    writeAddr_i = wa; writeEnable_i = we; bus_ack_i = 1'b0;
    stalls = 0;
    #1;
    if (stall_o) stalls++;
    tick();
    s_req = bus_req_o; s_we = bus_we_o; s_addr = bus_addr_o; s_be = bus_be_o; s_wdata = bus_wdata_o;
    for (int c = 1; c <= delay; c++) begin
      if (c == delay) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdata;
      end
      #1;
      if (stall_o) stalls++;
      tick();
      bus_ack_i = 1'b0;
    end
    memOp_i = 4'd0; writeEnable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; memOp_i = 4'd0; result_i = 32'hFFFF_FFFF; writeAddr_i = 5'd9;
    writeEnable_i = 1'b1; storeData_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    tick(); tick();
    total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    total++; if (writeEnable_o !== 1'b0 || writeAddr_o !== 5'd0) begin bad++; $display("FAIL reset_wb got we=%b wa=%0d exp 0/0", writeEnable_o, writeAddr_o); end
    total++; if ({bus_req_o, bus_we_o, bus_be_o} !== 6'd0 || bus_addr_o !== 32'd0 || bus_wdata_o !== 32'd0) begin bad++; $display("FAIL reset_bus got req=%b addr=%h be=%b exp zeros", bus_req_o, bus_addr_o, bus_be_o); end
    total++; if (misalign_o !== 1'b0 || bus_err_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL reset_flags got mis=%b err=%b stall=%b exp 0", misalign_o, bus_err_o, stall_o); end
    rst = 1'b0; writeEnable_i = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] res_t [3] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0007};
    logic [4:0]  wa_t  [3] = '{5'd5, 5'd31, 5'd1};
    logic        we_t  [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0]  op_t  [3] = '{4'd0, 4'd12, 4'd9};
    wb_t e;
    for (int i = 0; i < 3; i++) begin
      memOp_i = op_t[i]; result_i = res_t[i]; writeAddr_i = wa_t[i]; writeEnable_i = we_t[i];
      sb.push_back('{res_t[i], wa_t[i], we_t[i], 1'b1});
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL alu_stall[%0d] got=%b exp=0", i, stall_o); end
      tick();
      e = sb.pop_front();
      total++; if (result_o !== e.res || writeAddr_o !== e.wa || writeEnable_o !== e.we) begin bad++;
        $display("FAIL alu_wb[%0d] got %h/%0d/%b exp %h/%0d/%b", i, result_o, writeAddr_o, writeEnable_o, e.res, e.wa, e.we); end
    end
    writeEnable_i = 1'b0;
  endtask

  task automatic test_loads();
    logic [3:0]  op_t [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [31:0] ad_t [5] = '{32'h103, 32'h101, 32'h106, 32'h104, 32'h108};
    logic [31:0] rd_t [5] = '{32'h80FF_FFFF, 32'h0000_9A00, 32'h8001_1234, 32'h8001_F234, 32'h1234_5678};
    logic [31:0] ex_t [5] = '{32'hFFFF_FF80, 32'h0000_009A, 32'hFFFF_8001, 32'h0000_F234, 32'h1234_5678};
    int st; logic rq, w; logic [31:0] a, wd; logic [3:0] be;
    wb_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{ex_t[i], 5'(7 + i), 1'b1, 1'b1});
      run_mem(op_t[i], ad_t[i], 32'h0, 5'(7 + i), 1'b1, 3, rd_t[i], st, rq, w, a, be, wd);
      e = sb.pop_front();
      total++; if (rq !== 1'b1 || w !== 1'b0 || a !== {ad_t[i][31:2], 2'b00}) begin bad++;
        $display("FAIL load_req[%0d] got req=%b we=%b addr=%h exp 1/0/%h", i, rq, w, a, {ad_t[i][31:2], 2'b00}); end
      total++; if (result_o !== e.res || writeAddr_o !== e.wa || writeEnable_o !== e.we) begin bad++;
        $display("FAIL load_wb[%0d] got %h/%0d/%b exp %h/%0d/%b", i, result_o, writeAddr_o, writeEnable_o, e.res, e.wa, e.we); end
      total++; if (st !== 3 || bus_req_o !== 1'b0) begin bad++; $display("FAIL load_stall[%0d] got stalls=%0d req=%b exp 3/0", i, st, bus_req_o); end
    end
  endtask

  task automatic test_stores();
    logic [3:0]  op_t [3] = '{4'd7, 4'd6, 4'd8};
    logic [31:0] ad_t [3] = '{32'h202, 32'h003, 32'h010};
    logic [31:0] d_t  [3] = '{32'h0000_ABCD, 32'h1234_565A, 32'hCAFE_F00D};
    logic [31:0] ea_t [3] = '{32'h200, 32'h000, 32'h010};
    logic [3:0]  eb_t [3] = '{4'b1100, 4'b1000, 4'b1111};
    logic [31:0] ew_t [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    int st; logic rq, w; logic [31:0] a, wd; logic [3:0] be;
    wb_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0});
      run_mem(op_t[i], ad_t[i], d_t[i], 5'd3, 1'b1, 2, 32'hFFFF_FFFF, st, rq, w, a, be, wd);
      e = sb.pop_front();
      total++; if (rq !== 1'b1 || w !== 1'b1 || a !== ea_t[i] || be !== eb_t[i] || wd !== ew_t[i]) begin bad++;
        $display("FAIL store_bus[%0d] got req=%b we=%b addr=%h be=%b wd=%h exp 1/1/%h/%b/%h", i, rq, w, a, be, wd, ea_t[i], eb_t[i], ew_t[i]); end
      total++; if (writeEnable_o !== e.we || bus_req_o !== 1'b0 || st !== 2) begin bad++;
        $display("FAIL store_done[%0d] got we=%b req=%b stalls=%0d exp 0/0/2", i, writeEnable_o, bus_req_o, st); end
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  op_t [3] = '{4'd5, 4'd7, 4'd3};
    logic [31:0] ad_t [3] = '{32'h101, 32'h201, 32'h0FF};
    for (int i = 0; i < 3; i++) begin
      memOp_i = op_t[i]; result_i = ad_t[i]; writeAddr_i = 5'd3; writeEnable_i = 1'b1; storeData_i = 32'h55;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mis_stall[%0d] got=%b exp=0", i, stall_o); end
      tick();
      total++; if (misalign_o !== 1'b1 || bus_req_o !== 1'b0 || writeEnable_o !== 1'b0) begin bad++;
        $display("FAIL mis_pulse[%0d] got mis=%b req=%b we=%b exp 1/0/0", i, misalign_o, bus_req_o, writeEnable_o); end
      memOp_i = 4'd0; writeEnable_i = 1'b0;
      tick();
      total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_end[%0d] got=%b exp=0", i, misalign_o); end
    end
  endtask

  task automatic test_timeout();
    int n; logic last_stall;
    memOp_i = 4'd5; result_i = 32'h40; writeAddr_i = 5'd4; writeEnable_i = 1'b1; bus_ack_i = 1'b0;
    tick();
    n = 0; last_stall = 1'b1;
    while (n < 20) begin
      #1; last_stall = stall_o;
      tick(); n++;
      if (bus_err_o === 1'b1) break;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL timeout_cycles got=%0d exp=4", n); end
    total++; if (bus_req_o !== 1'b0 || writeEnable_o !== 1'b0 || last_stall !== 1'b0) begin bad++;
      $display("FAIL timeout_state got req=%b we=%b stall=%b exp 0/0/0", bus_req_o, writeEnable_o, last_stall); end
    memOp_i = 4'd0; writeEnable_i = 1'b0;
    tick();
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b exp=0", bus_err_o); end
  endtask

  task automatic test_ack_wins();
    int st; logic rq, w; logic [31:0] a, wd; logic [3:0] be;
    wb_t e;
    sb.push_back('{32'h0000_00BE, 5'd12, 1'b1, 1'b1});
    run_mem(4'd2, 32'h30, 32'h0, 5'd12, 1'b1, 4, 32'h00BE_0000 >> 16, st, rq, w, a, be, wd);
    e = sb.pop_front();
    total++; if (bus_err_o !== 1'b0 || result_o !== e.res || writeEnable_o !== e.we) begin bad++;
      $display("FAIL ack_wins got err=%b res=%h we=%b exp 0/%h/%b", bus_err_o, result_o, writeEnable_o, e.res, e.we); end
  endtask

  task automatic test_back_to_back();
    int st; logic rq, w; logic [31:0] a, wd; logic [3:0] be;
    wb_t e;
    sb.push_back('{32'h1111_2222, 5'd20, 1'b1, 1'b1});
    run_mem(4'd5, 32'h80, 32'h0, 5'd20, 1'b1, 1, 32'h1111_2222, st, rq, w, a, be, wd);
    e = sb.pop_front();
    total++; if (result_o !== e.res || writeEnable_o !== e.we || st !== 1) begin bad++;
      $display("FAIL b2b_first got res=%h we=%b stalls=%0d exp %h/%b/1", result_o, writeEnable_o, st, e.res, e.we); end
    sb.push_back('{32'hFFFF_FFF0, 5'd21, 1'b1, 1'b1});
    run_mem(4'd1, 32'h85, 32'h0, 5'd21, 1'b1, 1, 32'h0000_F000, st, rq, w, a, be, wd);
    e = sb.pop_front();
    total++; if (result_o !== e.res || writeAddr_o !== e.wa || writeEnable_o !== e.we) begin bad++;
      $display("FAIL b2b_second got %h/%0d/%b exp %h/%0d/%b", result_o, writeAddr_o, writeEnable_o, e.res, e.wa, e.we); end
    memOp_i = 4'd0; result_i = 32'h77; writeAddr_i = 5'd2; writeEnable_i = 1'b1; bus_ack_i = 1'b1;
    sb.push_back('{32'h77, 5'd2, 1'b1, 1'b1});
    tick();
    bus_ack_i = 1'b0;
    e = sb.pop_front();
    total++; if (result_o !== e.res || writeEnable_o !== e.we || bus_req_o !== 1'b0) begin bad++;
      $display("FAIL idle_ack got res=%h we=%b req=%b exp %h/%b/0", result_o, writeEnable_o, bus_req_o, e.res, e.we); end
    writeEnable_i = 1'b0;
  endtask

  task automatic test_reset_busy();
    wb_t e;
    memOp_i = 4'd8; result_i = 32'h60; storeData_i = 32'h1234_5678; writeAddr_i = 5'd6; writeEnable_i = 1'b1;
    tick();
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rstbusy_issue got req=%b exp=1", bus_req_o); end
    rst = 1'b1; memOp_i = 4'd0;
    tick();
    #1;
    total++; if (bus_req_o !== 1'b0 || result_o !== 32'd0 || writeEnable_o !== 1'b0 || bus_addr_o !== 32'd0 || stall_o !== 1'b0) begin bad++;
      $display("FAIL rstbusy_clear got req=%b res=%h we=%b addr=%h stall=%b exp zeros", bus_req_o, result_o, writeEnable_o, bus_addr_o, stall_o); end
    rst = 1'b0; result_i = 32'h0000_1234; writeAddr_i = 5'd5; writeEnable_i = 1'b1;
    sb.push_back('{32'h0000_1234, 5'd5, 1'b1, 1'b1});
    tick();
    e = sb.pop_front();
    total++; if (result_o !== e.res || writeAddr_o !== e.wa || writeEnable_o !== e.we || stall_o !== 1'b0) begin bad++;
      $display("FAIL rstbusy_after got %h/%0d/%b stall=%b exp %h/%0d/%b/0", result_o, writeAddr_o, writeEnable_o, stall_o, e.res, e.wa, e.we); end
    writeEnable_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_ack_wins();
    test_back_to_back();
    test_reset_busy();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
